// File: rtl/fnd_scan_controller_if.sv
// fnd_scan_controller_if: time counters in, FND digit enables and segments out
interface fnd_scan_controller_if;
  logic       sw_mode;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;
  modport master (output sw_mode, msec, sec, min, hour, input fnd_comm, fnd_font);
  modport slave  (input sw_mode, msec, sec, min, hour, output fnd_comm, fnd_font);
endinterface

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller: 4-digit common-anode FND scanner fed from a per-frame snapshot
module fnd_scan_controller #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input logic                  clk,
  input logic                  rst,
  fnd_scan_controller_if.slave bus
);
  localparam int N  = CLK_HZ / SCAN_HZ;
  localparam int CW = $clog2(N);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic          r_mode_s;
  logic [6:0]    r_msec_s;
  logic [5:0]    r_sec_s;
  logic [5:0]    r_min_s;
  logic [4:0]    r_hour_s;
  logic [3:0]    r_comm;
  logic [7:0]    r_font;
  logic          w_tick;
  logic [6:0]    w_lo;
  logic [6:0]    w_hi;
  logic [6:0]    w_v;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic          w_dp;
  assign w_tick       = r_cnt == CW'(N - 1);
  assign bus.fnd_comm = r_comm;
  assign bus.fnd_font = r_font;
  // Pick the low/high pair by snapshot mode, then the decimal digit selected by r_sel
  always_comb begin
    w_lo    = r_mode_s ? r_msec_s : 7'(r_min_s);
    w_hi    = r_mode_s ? 7'(r_sec_s) : 7'(r_hour_s);
    w_v     = r_sel[1] ? w_hi : w_lo;
    w_digit = r_sel[0] ? 4'((w_v / 7'd10) % 7'd10) : 4'(w_v % 7'd10);
    w_dp    = !(r_sel == 2'd2 && r_msec_s < 7'd50);
  end
  // Active-low {g,f,e,d,c,b,a} pattern for the selected digit
  always_comb begin
    w_seg = 7'h7F;
    case (w_digit)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end
  // Scan divider, digit select, registered outputs and end-of-frame snapshot load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_sel    <= '0;
      r_mode_s <= 1'b0;
      r_msec_s <= '0;
      r_sec_s  <= '0;
      r_min_s  <= '0;
      r_hour_s <= '0;
      r_comm   <= 4'b1111;
      r_font   <= 8'hFF;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_sel  <= r_sel + 2'd1;
        r_comm <= ~(4'b0001 << r_sel);
        r_font <= {w_dp, w_seg};
        if (r_sel == 2'd3) begin
          r_mode_s <= bus.sw_mode;
          r_msec_s <= bus.msec;
          r_sec_s  <= bus.sec;
          r_min_s  <= bus.min;
          r_hour_s <= bus.hour;
        end
      end
    end
  end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller: directed-vector bench for the FND scan controller (N = 10)
module tb_fnd_scan_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int bsel = 0;
  fnd_scan_controller_if bus();
  fnd_scan_controller #(.CLK_HZ(100), .SCAN_HZ(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step_digit;
    repeat (10) @(posedge clk);
    #1;
    bsel = (bsel + 1) % 4;
  endtask
  task automatic sync_frame;
    step_digit();
    while (bsel != 0) step_digit();
  endtask
  task automatic test_reset;
    bus.sw_mode = 1'b0;
    bus.msec = 7'd0;
    bus.sec = 6'd0;
    bus.min = 6'd0;
    bus.hour = 5'd0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.fnd_comm !== 4'b1111 || bus.fnd_font !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_hold: comm=%b font=%h, expected comm=1111 font=ff", bus.fnd_comm, bus.fnd_font);
    end
    @(negedge clk);
    rst = 1'b1;
    bsel = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.fnd_comm !== 4'b1111 || bus.fnd_font !== 8'hFF) begin
        miscompares++;
        $display("FAIL reset_dark_cycle%0d: comm=%b font=%h, expected comm=1111 font=ff", i, bus.fnd_comm, bus.fnd_font);
      end
    end
    @(posedge clk);
    #1;
    bsel = 1;
    vectors++;
    if (bus.fnd_comm !== 4'b1110 || bus.fnd_font !== 8'hC0) begin
      miscompares++;
      $display("FAIL reset_first_tick: comm=%b font=%h, expected comm=1110 font=c0", bus.fnd_comm, bus.fnd_font);
    end
  endtask
  task automatic test_mode0;
    logic [7:0] ef [4];
    logic [3:0] ec [4];
    ef = '{8'h92, 8'h99, 8'h30, 8'hF9};
    ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus.sw_mode = 1'b0;
    bus.hour = 5'd13;
    bus.min = 6'd45;
    bus.msec = 7'd10;
    bus.sec = 6'd0;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      step_digit();
      vectors++;
      if (bus.fnd_comm !== ec[k] || bus.fnd_font !== ef[k]) begin
        miscompares++;
        $display("FAIL mode0_d%0d: comm=%b font=%h, expected comm=%b font=%h", k, bus.fnd_comm, bus.fnd_font, ec[k], ef[k]);
      end
    end
  endtask
  task automatic test_mode1;
    logic [7:0] ef [4];
    logic [3:0] ec [4];
    ef = '{8'h90, 8'h90, 8'hF8, 8'hC0};
    ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus.sw_mode = 1'b1;
    bus.sec = 6'd7;
    bus.msec = 7'd99;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      step_digit();
      vectors++;
      if (bus.fnd_comm !== ec[k] || bus.fnd_font !== ef[k]) begin
        miscompares++;
        $display("FAIL mode1_d%0d: comm=%b font=%h, expected comm=%b font=%h", k, bus.fnd_comm, bus.fnd_font, ec[k], ef[k]);
      end
    end
  endtask
  task automatic test_mid_frame;
    logic [7:0] ef [4];
    logic [3:0] ec [4];
    ef = '{8'h92, 8'h99, 8'h30, 8'hF9};
    ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus.sw_mode = 1'b0;
    bus.hour = 5'd13;
    bus.min = 6'd45;
    bus.msec = 7'd10;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      step_digit();
      if (k == 0) bus.min = 6'd46;
      vectors++;
      if (bus.fnd_comm !== ec[k] || bus.fnd_font !== ef[k]) begin
        miscompares++;
        $display("FAIL midframe_d%0d: comm=%b font=%h, expected comm=%b font=%h", k, bus.fnd_comm, bus.fnd_font, ec[k], ef[k]);
      end
    end
    step_digit();
    vectors++;
    if (bus.fnd_comm !== 4'b1110 || bus.fnd_font !== 8'h82) begin
      miscompares++;
      $display("FAIL midframe_next_d0: comm=%b font=%h, expected comm=1110 font=82", bus.fnd_comm, bus.fnd_font);
    end
    repeat (3) step_digit();
  endtask
  task automatic test_out_of_range;
    logic [7:0] ef [4];
    logic [3:0] ec [4];
    ef = '{8'hF8, 8'hA4, 8'hF8, 8'hC0};
    ec = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus.sw_mode = 1'b1;
    bus.msec = 7'd127;
    bus.sec = 6'd7;
    sync_frame();
    for (int k = 0; k < 4; k++) begin
      step_digit();
      vectors++;
      if (bus.fnd_comm !== ec[k] || bus.fnd_font !== ef[k]) begin
        miscompares++;
        $display("FAIL range_d%0d: comm=%b font=%h, expected comm=%b font=%h", k, bus.fnd_comm, bus.fnd_font, ec[k], ef[k]);
      end
    end
  endtask
  task automatic test_async_reset;
    step_digit();
    step_digit();
    vectors++;
    if (bus.fnd_comm !== 4'b1101 || bus.fnd_font !== 8'hA4) begin
      miscompares++;
      $display("FAIL async_pre_d1: comm=%b font=%h, expected comm=1101 font=a4", bus.fnd_comm, bus.fnd_font);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.fnd_comm !== 4'b1111 || bus.fnd_font !== 8'hFF) begin
      miscompares++;
      $display("FAIL async_immediate: comm=%b font=%h, expected comm=1111 font=ff", bus.fnd_comm, bus.fnd_font);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bsel = 0;
    repeat (9) @(posedge clk);
    #1;
    vectors++;
    if (bus.fnd_comm !== 4'b1111 || bus.fnd_font !== 8'hFF) begin
      miscompares++;
      $display("FAIL async_dark_cycle9: comm=%b font=%h, expected comm=1111 font=ff", bus.fnd_comm, bus.fnd_font);
    end
    @(posedge clk);
    #1;
    bsel = 1;
    vectors++;
    if (bus.fnd_comm !== 4'b1110 || bus.fnd_font !== 8'hC0) begin
      miscompares++;
      $display("FAIL async_first_tick: comm=%b font=%h, expected comm=1110 font=c0", bus.fnd_comm, bus.fnd_font);
    end
  endtask
  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mid_frame();
    test_out_of_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end
endmodule
